// File: rtl/bar_viz_pkg.sv
// Shared definitions for the bubble-sort visualiser: colours, OLED geometry,
// sorter states and the LFSR step used to generate fresh element values.
package bar_viz_pkg;

    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] CMP_YELLOW  = 16'hFFE0;
    localparam logic [15:0] SORTED_BLUE = 16'h001F;
    localparam logic [15:0] BG_BLACK    = 16'h0000;

    localparam int OLED_W = 96;
    localparam int OLED_H = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_COMPARE,
        ST_SWAP,
        ST_DONE
    } sort_state_t;

    // One step of the 16-bit Galois LFSR with feedback mask 16'hB400.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

endpackage

// File: rtl/bar_renderer.sv
// Turns the element array into coloured vertical bars on the 96x64 OLED.
// The colour for a pixel index appears on pixel_data one cycle later.
module bar_renderer
    import bar_viz_pkg::*;
#(
    parameter int N_BARS      = 8,
    parameter int VAL_W       = 6,
    parameter int BAR_WIDTH   = 8,
    parameter int BAR_SPACING = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [12:0]               pixel_index,
    input  logic [N_BARS*VAL_W-1:0]   values_flat,
    input  logic [3:0]                j,
    input  logic [3:0]                pass,
    input  logic                      busy,
    input  logic                      done,
    output logic [15:0]               pixel_data
);

    localparam int PITCH = BAR_WIDTH + BAR_SPACING;

    int          x;
    int          y;
    int          slot;
    int          off;
    int          height;
    logic        in_bar;
    logic [15:0] colour;

    // Decode the pixel position into a bar slot and pick its colour.
    always_comb begin
        x      = int'(pixel_index) % OLED_W;
        y      = int'(pixel_index) / OLED_W;
        slot   = x / PITCH;
        off    = x % PITCH;
        height = 0;
        if (slot < N_BARS) begin
            height = int'(values_flat[slot*VAL_W +: VAL_W]) >> (VAL_W - 6);
        end
        in_bar = (slot < N_BARS) && (off < BAR_WIDTH) && (y < OLED_H) &&
                 ((OLED_H - 1 - y) < height);
        colour = BG_BLACK;
        if (in_bar) begin
            if (done || (busy && (slot >= N_BARS - int'(pass)))) begin
                colour = SORTED_BLUE;
            end else if (busy && ((slot == int'(j)) || (slot == int'(j) + 1))) begin
                colour = CMP_YELLOW;
            end else begin
                colour = BAR_GREEN;
            end
        end
    end

    // Register the colour so the display sees a fixed one-cycle latency.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pixel_data <= BG_BLACK;
        end else begin
            pixel_data <= colour;
        end
    end

endmodule

// File: rtl/bubble_sort_engine.sv
// Paced bubble sort over N_BARS elements with pause/single-step control,
// LFSR reloading, early termination and an OLED bar-chart view.
module bubble_sort_engine
    import bar_viz_pkg::*;
#(
    parameter int          N_BARS      = 8,
    parameter int          VAL_W       = 6,
    parameter int          STEP_CYCLES = 25000000,
    parameter int          BAR_WIDTH   = 8,
    parameter int          BAR_SPACING = 2,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic                      randomize,
    input  logic                      pause,
    input  logic                      single_step,
    input  logic [12:0]               pixel_index,
    output logic [15:0]               pixel_data,
    output logic [N_BARS*VAL_W-1:0]   values_flat,
    output logic [3:0]                cmp_idx,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               swap_count
);

    sort_state_t               state;
    sort_state_t               state_next;
    logic [N_BARS*VAL_W-1:0]   vals;
    logic [3:0]                j;
    logic [3:0]                pass;
    logic [3:0]                load_cnt;
    logic                      swapped_flag;
    logic [31:0]               timer;
    logic [15:0]               lfsr;
    logic [VAL_W-1:0]          left;
    logic [VAL_W-1:0]          right;
    logic                      step_go;
    logic                      adv_j;
    logic                      adv_pass;
    logic                      last_j;
    logic                      finished;

    assign left        = vals[32'(j)*VAL_W +: VAL_W];
    assign right       = vals[(32'(j)+1)*VAL_W +: VAL_W];
    assign values_flat = vals;
    assign cmp_idx     = j;
    assign busy        = (state == ST_WAIT) || (state == ST_COMPARE) || (state == ST_SWAP);
    assign done        = (state == ST_DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the step/advance strobes for the datapath.
    always_comb begin
        state_next = state;
        step_go    = 1'b0;
        adv_j      = 1'b0;
        adv_pass   = 1'b0;
        last_j     = (int'(j) >= N_BARS - 2 - int'(pass));
        finished   = (int'(pass) == N_BARS - 2) || !(swapped_flag || (state == ST_SWAP));
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (randomize) begin
                    state_next = ST_LOAD;
                end else if (start) begin
                    state_next = ST_WAIT;
                end
            end
            ST_LOAD: begin
                if (int'(load_cnt) == N_BARS - 1) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if ((pause && single_step) || (!pause && (timer == 32'(STEP_CYCLES - 1)))) begin
                    step_go    = 1'b1;
                    state_next = ST_COMPARE;
                end
            end
            ST_COMPARE, ST_SWAP: begin
                if ((state == ST_COMPARE) && (left > right)) begin
                    state_next = ST_SWAP;
                end else if (!last_j) begin
                    adv_j      = 1'b1;
                    state_next = ST_WAIT;
                end else if (finished) begin
                    state_next = ST_DONE;
                end else begin
                    adv_pass   = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: element array, sort indices, step timer, swap counter, LFSR.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < N_BARS; i++) begin
                vals[i*VAL_W +: VAL_W] <= VAL_W'(((N_BARS - i) * ((1 << VAL_W) - 1)) / N_BARS);
            end
            j            <= 4'd0;
            pass         <= 4'd0;
            load_cnt     <= 4'd0;
            swapped_flag <= 1'b0;
            swap_count   <= 16'd0;
            timer        <= 32'd0;
            lfsr         <= SEED;
        end else begin
            lfsr <= lfsr_step(lfsr);
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (randomize) begin
                        load_cnt <= 4'd0;
                    end else if (start) begin
                        pass         <= 4'd0;
                        j            <= 4'd0;
                        swapped_flag <= 1'b0;
                        swap_count   <= 16'd0;
                        timer        <= 32'd0;
                    end
                end
                ST_LOAD: begin
                    vals[32'(load_cnt)*VAL_W +: VAL_W] <= lfsr[VAL_W-1:0];
                    load_cnt <= load_cnt + 4'd1;
                end
                ST_WAIT: begin
                    if (step_go) begin
                        timer <= 32'd0;
                    end else if (!pause) begin
                        timer <= timer + 32'd1;
                    end
                end
                ST_SWAP: begin
                    vals[32'(j)*VAL_W +: VAL_W]      <= right;
                    vals[(32'(j)+1)*VAL_W +: VAL_W]  <= left;
                    swapped_flag <= 1'b1;
                    if (swap_count != 16'hFFFF) begin
                        swap_count <= swap_count + 16'd1;
                    end
                end
                default: begin
                end
            endcase
            if (adv_j) begin
                j <= j + 4'd1;
            end
            if (adv_pass) begin
                pass         <= pass + 4'd1;
                j            <= 4'd0;
                swapped_flag <= 1'b0;
            end
        end
    end

    bar_renderer #(
        .N_BARS      (N_BARS),
        .VAL_W       (VAL_W),
        .BAR_WIDTH   (BAR_WIDTH),
        .BAR_SPACING (BAR_SPACING)
    ) u_renderer (
        .clk         (clk),
        .resetn      (resetn),
        .pixel_index (pixel_index),
        .values_flat (vals),
        .j           (j),
        .pass        (pass),
        .busy        (busy),
        .done        (done),
        .pixel_data  (pixel_data)
    );

endmodule
